uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_arbiter_if.sv | 48 ++++
 rtl/rr_pick2.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   - arb_state_t      : 3-bit encoded arbiter FSM states
//   - IDLE_BYTE        : value parked on data_out after reset
//   - ACK_TIMEOUT_DEFAULT : default busy-handshake timeout in cycles
//   - GRANT_* constants: one-hot grant codes (00 = nobody owns the UART)
//   - favour_after()   : round-robin pointer value once a packet is retired
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        NEXT      = 3'd4
    } arb_state_t;

    localparam logic [7:0] IDLE_BYTE           = 8'hFF;
    localparam int         ACK_TIMEOUT_DEFAULT = 1024;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    // The pointer is a single bit: 0 favours source 0, 1 favours source 1.
    // Once a packet from a source is retired, the other source becomes the
    // favoured one, so the new pointer is simply "was it source 0".
    function automatic logic favour_after(input logic [1:0] served);
        return served[0];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the two byte-stream sources and the UART transmitter handshake
// seen by the arbiter.
//   s0_valid/s0_data/s0_last/s0_ready : source 0 (image stream)
//   s1_valid/s1_data/s1_last/s1_ready : source 1 (status/debug)
//   data_out/tx_req/tx_busy           : transmitter byte + request/busy
//   grant                             : one-hot owner, 00 = none
//   err_timeout                       : pulse when tx_busy never rose
// Modports:
//   master : the arbiter (drives ready, data_out, tx_req, grant, err)
//   slave  : the surrounding system (sources and transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if;

    logic       s0_valid;
    logic [7:0] s0_data;
    logic       s0_last;
    logic       s0_ready;

    logic       s1_valid;
    logic [7:0] s1_data;
    logic       s1_last;
    logic       s1_ready;

    logic [7:0] data_out;
    logic       tx_req;
    logic       tx_busy;
    logic [1:0] grant;
    logic       err_timeout;

    modport master (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        input  tx_busy,
        output s0_ready, s1_ready,
        output data_out, tx_req, grant, err_timeout
    );

    modport slave (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        output tx_busy,
        input  s0_ready, s1_ready,
        input  data_out, tx_req, grant, err_timeout
    );

endinterface

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick.
//   valid[1:0] : request from source 1 / source 0
//   pointer    : 0 favours source 0, 1 favours source 1 on a tie
//   winner[1:0]: one-hot winner, 00 when nobody requests
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] winner
);

    // A lone requester always wins; the pointer only matters on a tie.
    always_comb begin
        winner = 2'b00;
        case (valid)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = pointer ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between two byte-stream sources. Ownership
// is decided per packet with a round-robin pointer and held until the
// packet's last byte has been transmitted (or the handshake times out).
// Each byte goes through LOAD -> WAIT_BUSY -> WAIT_DONE; multi-byte packets
// park in NEXT between bytes waiting for the owner to present more data.
//
// Parameters:
//   ACK_TIMEOUT : cycles allowed for tx_busy to rise after tx_req rises
// Ports:
//   SYS_CLK : sole clock, rising edge
//   RST     : synchronous, active-high reset
//   bus     : uart_tx_arbiter_if.master (sources + transmitter handshake)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    uart_tx_arbiter_if.master      bus
);

    // One extra bit over log2 so the compare value fits without wrapping.
    localparam int                 CNT_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_t         state_q;
    logic [1:0]         grant_q;
    logic               ptr_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tx_req_q;
    logic [7:0]         data_q;
    logic               rdy0_q;
    logic               rdy1_q;
    logic               err_q;

    logic [1:0]         winner;
    logic               sel_valid;
    logic [7:0]         sel_data;
    logic               sel_last;

    rr_pick2 u_pick (
        .valid   ({bus.s1_valid, bus.s0_valid}),
        .pointer (ptr_q),
        .winner  (winner)
    );

    // Steer the currently granted source onto a single set of signals so the
    // FSM does not care which source it is serving. With no grant the values
    // are don't-care; source 0 is returned simply as a fixed default.
    always_comb begin
        sel_valid = bus.s0_valid;
        sel_data  = bus.s0_data;
        sel_last  = bus.s0_last;
        if (grant_q[1]) begin
            sel_valid = bus.s1_valid;
            sel_data  = bus.s1_data;
            sel_last  = bus.s1_last;
        end
    end

    // Arbiter FSM with every output registered. Ready is raised on the edge
    // that enters LOAD so it is high exactly during the LOAD cycle, and the
    // byte is captured on the edge that leaves LOAD. A reset wipes any byte
    // in flight without producing a ready or error pulse.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= GRANT_NONE;
            ptr_q    <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            tx_req_q <= 1'b0;
            data_q   <= IDLE_BYTE;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (|winner) begin
                        grant_q <= winner;
                        rdy0_q  <= winner[0];
                        rdy1_q  <= winner[1];
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    data_q   <= sel_data;
                    last_q   <= sel_last;
                    tx_req_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= WAIT_BUSY;
                end

                // The counter holds the number of cycles already spent
                // waiting, so hitting ACK_TIMEOUT-1 here means tx_req has been
                // high for ACK_TIMEOUT cycles by the time it drops.
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        tx_req_q <= 1'b0;
                        state_q  <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        tx_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        grant_q  <= GRANT_NONE;
                        ptr_q    <= favour_after(grant_q);
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            grant_q <= GRANT_NONE;
                            ptr_q   <= favour_after(grant_q);
                            state_q <= IDLE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end

                // Mid-packet: only the owner can move us on, the other
                // source is ignored however long this takes.
                NEXT: begin
                    if (sel_valid) begin
                        rdy0_q  <= grant_q[0];
                        rdy1_q  <= grant_q[1];
                        state_q <= LOAD;
                    end
                end

                default: begin
                    tx_req_q <= 1'b0;
                    grant_q  <= GRANT_NONE;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.s0_ready    = rdy0_q;
    assign bus.s1_ready    = rdy1_q;
    assign bus.data_out    = data_q;
    assign bus.tx_req      = tx_req_q;
    assign bus.grant       = grant_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Two source drivers feed byte
// queues, a transmitter model raises tx_busy one cycle after tx_req, and a
// scoreboard holds the expected bytes per source plus the expected order of
// packet grants. Runs with ACK_TIMEOUT = 16.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    import uart_pkg::*;

    localparam int TB_ACK_TIMEOUT = 16;

    logic SYS_CLK = 1'b0;
    logic RST     = 1'b1;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .ACK_TIMEOUT (TB_ACK_TIMEOUT)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         cycle        = 0;

    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    logic [8:0] exp0_q[$];
    logic [8:0] exp1_q[$];
    logic [1:0] exp_grant_q[$];

    bit         pause0         = 1'b0;
    bit         ignore_busy    = 1'b0;
    bit         expect_timeout = 1'b0;
    bit         in_packet      = 1'b0;
    logic [1:0] owner          = 2'b00;

    int         n_ready0       = 0;
    int         n_ready1       = 0;
    int         n_req_rise     = 0;
    int         n_timeout      = 0;
    int         req_rise_cycle = 0;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
        end
    endtask

    // Queue one byte on a source; optionally record it as expected output.
    task automatic applyStimulus(input logic src, input logic [7:0] data,
                                 input logic last, input logic expect_tx);
        if (src == 1'b0) begin
            src0_q.push_back({last, data});
            if (expect_tx) exp0_q.push_back({last, data});
        end else begin
            src1_q.push_back({last, data});
            if (expect_tx) exp1_q.push_back({last, data});
        end
    endtask

    task automatic expectPacket(input logic [1:0] g);
        exp_grant_q.push_back(g);
    endtask

    // Called by the transmitter model when it accepts a byte.
    task automatic captureByte();
        logic [8:0] exp_item;
        if (!in_packet) begin
            if (exp_grant_q.size() == 0) begin
                checkOutput("packet_expected", 32'(exp_grant_q.size()), 32'd1);
                return;
            end
            owner     = exp_grant_q.pop_front();
            in_packet = 1'b1;
        end
        checkOutput("grant_owner", 32'(bus.grant), 32'(owner));
        if (owner == GRANT_S0) begin
            if (exp0_q.size() == 0) begin
                checkOutput("s0_byte_expected", 32'(exp0_q.size()), 32'd1);
                return;
            end
            exp_item = exp0_q.pop_front();
        end else begin
            if (exp1_q.size() == 0) begin
                checkOutput("s1_byte_expected", 32'(exp1_q.size()), 32'd1);
                return;
            end
            exp_item = exp1_q.pop_front();
        end
        checkOutput("data_out", 32'(bus.data_out), 32'(exp_item[7:0]));
        if (exp_item[8]) in_packet = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge SYS_CLK);
            #1;
            done = (src0_q.size() == 0) && (src1_q.size() == 0) &&
                   (exp0_q.size() == 0) && (exp1_q.size() == 0) &&
                   (exp_grant_q.size() == 0) && !in_packet &&
                   (bus.grant == GRANT_NONE) && !bus.tx_req && !bus.tx_busy;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic waitReqHigh(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge SYS_CLK);
            #1;
            seen = bus.tx_req;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic doReset();
        @(negedge SYS_CLK);
        RST = 1'b1;
        repeat (2) @(negedge SYS_CLK);
        RST = 1'b0;
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge SYS_CLK);
            cycle++;
        end
    end

    // Source drivers: present the head of each queue; a ready seen during a
    // cycle means the byte is consumed at the following edge, so the head is
    // dropped at the next falling edge.
    initial begin : src_driver
        bit adv0;
        bit adv1;
        adv0 = 1'b0;
        adv1 = 1'b0;
        bus.s0_valid = 1'b0;
        bus.s0_data  = 8'h00;
        bus.s0_last  = 1'b0;
        bus.s1_valid = 1'b0;
        bus.s1_data  = 8'h00;
        bus.s1_last  = 1'b0;
        forever begin
            @(negedge SYS_CLK);
            if (adv0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (adv1 && src1_q.size() > 0) void'(src1_q.pop_front());
            adv0 = bus.s0_ready;
            adv1 = bus.s1_ready;
            bus.s0_valid = (src0_q.size() > 0) && !pause0;
            if (src0_q.size() > 0) begin
                bus.s0_data = src0_q[0][7:0];
                bus.s0_last = src0_q[0][8];
            end
            bus.s1_valid = (src1_q.size() > 0);
            if (src1_q.size() > 0) begin
                bus.s1_data = src1_q[0][7:0];
                bus.s1_last = src1_q[0][8];
            end
        end
    end

    // Transmitter: accepts a request at the falling edge, busy for two edges.
    initial begin : tx_model
        int hold;
        hold = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge SYS_CLK);
            if (RST) begin
                bus.tx_busy = 1'b0;
                hold        = 0;
            end else if (bus.tx_busy) begin
                if (hold == 0) bus.tx_busy = 1'b0;
                else           hold--;
            end else if (bus.tx_req && !ignore_busy) begin
                captureByte();
                bus.tx_busy = 1'b1;
                hold        = 1;
            end
        end
    end

    initial begin : monitor
        bit prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge SYS_CLK);
            if (bus.s0_ready) begin
                n_ready0++;
                checkOutput("s0_ready_owner", 32'(bus.grant), 32'(GRANT_S0));
            end
            if (bus.s1_ready) begin
                n_ready1++;
                checkOutput("s1_ready_owner", 32'(bus.grant), 32'(GRANT_S1));
            end
            if (bus.tx_req && !prev_req) begin
                n_req_rise++;
                req_rise_cycle = cycle;
            end
            prev_req = bus.tx_req;
            if (bus.err_timeout) begin
                checkOutput("err_expected", 32'(expect_timeout), 32'd1);
                if (expect_timeout) begin
                    checkOutput("timeout_delay", 32'(cycle - req_rise_cycle),
                                32'(TB_ACK_TIMEOUT));
                    checkOutput("timeout_req_low", 32'(bus.tx_req), 32'd0);
                    checkOutput("timeout_grant", 32'(bus.grant), 32'(GRANT_NONE));
                end
                expect_timeout = 1'b0;
                ignore_busy    = 1'b0;
                n_timeout++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base0;
        int base1;
        int c_valid;
        int rises;
        bit seen;

        // Reset values
        RST = 1'b1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        checkOutput("rst_data_out", 32'(bus.data_out), 32'(IDLE_BYTE));
        checkOutput("rst_grant", 32'(bus.grant), 32'(GRANT_NONE));
        checkOutput("rst_tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("rst_ready", 32'({bus.s1_ready, bus.s0_ready}), 32'd0);
        checkOutput("rst_err", 32'(bus.err_timeout), 32'd0);
        @(negedge SYS_CLK);
        RST = 1'b0;

        // Single 3-byte packet from source 0, plus first-request latency
        $display("[TB] single packet from source 0");
        base0 = n_ready0;
        base1 = n_ready1;
        expectPacket(GRANT_S0);
        applyStimulus(1'b0, 8'h01, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hFE, 1'b1, 1'b1);
        seen = 1'b0;
        c_valid = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge SYS_CLK);
            #1;
            seen    = bus.s0_valid;
            c_valid = cycle;
        end
        waitReqHigh("first_req_wait", 10);
        checkOutput("first_req_latency", 32'(cycle - c_valid), 32'd2);
        waitIdle("single_idle", 200);
        checkOutput("s0_ready_pulses", 32'(n_ready0 - base0), 32'd3);
        checkOutput("s1_ready_pulses", 32'(n_ready1 - base1), 32'd0);

        // Simultaneous request after reset: source 0 first, whole packet
        $display("[TB] simultaneous request after reset");
        doReset();
        expectPacket(GRANT_S0);
        expectPacket(GRANT_S1);
        applyStimulus(1'b0, 8'h10, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h12, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h21, 1'b1, 1'b1);
        waitIdle("simul_idle", 300);

        // Back-to-back packets from both sources: grants alternate
        $display("[TB] back-to-back alternation");
        expectPacket(GRANT_S0);
        expectPacket(GRANT_S1);
        expectPacket(GRANT_S0);
        expectPacket(GRANT_S1);
        applyStimulus(1'b0, 8'h30, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h31, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h32, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h33, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h42, 1'b1, 1'b1);
        waitIdle("alternate_idle", 400);

        // Source 0 stalls mid-packet while source 1 waits
        $display("[TB] mid-packet stall");
        base0 = n_ready0;
        base1 = n_ready1;
        expectPacket(GRANT_S0);
        expectPacket(GRANT_S1);
        applyStimulus(1'b0, 8'h50, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h51, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h52, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h60, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge SYS_CLK);
            #1;
            seen = (n_ready0 != base0);
        end
        checkOutput("stall_first_ready", 32'(seen), 32'd1);
        pause0 = 1'b1;
        repeat (20) @(negedge SYS_CLK);
        #1;
        checkOutput("stall_grant_held", 32'(bus.grant), 32'(GRANT_S0));
        checkOutput("stall_s1_ready", 32'(n_ready1 - base1), 32'd0);
        checkOutput("stall_tx_req", 32'(bus.tx_req), 32'd0);
        pause0 = 1'b0;
        waitIdle("stall_idle", 300);

        // Transmitter never goes busy: timeout, then the other source
        $display("[TB] handshake timeout");
        ignore_busy    = 1'b1;
        expect_timeout = 1'b1;
        rises          = n_timeout;
        applyStimulus(1'b0, 8'h44, 1'b1, 1'b0);
        waitReqHigh("timeout_req_wait", 10);
        expectPacket(GRANT_S1);
        expectPacket(GRANT_S0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h66, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge SYS_CLK);
            #1;
            seen = (n_timeout != rises);
        end
        checkOutput("timeout_seen", 32'(seen), 32'd1);
        ignore_busy    = 1'b0;
        expect_timeout = 1'b0;
        waitIdle("timeout_idle", 300);

        // Reset while waiting for busy
        $display("[TB] reset during WAIT_BUSY");
        ignore_busy = 1'b1;
        applyStimulus(1'b0, 8'h77, 1'b1, 1'b0);
        waitReqHigh("rst_req_wait", 10);
        repeat (3) @(negedge SYS_CLK);
        RST = 1'b1;
        @(posedge SYS_CLK);
        #1;
        checkOutput("midrst_tx_req", 32'(bus.tx_req), 32'd0);
        checkOutput("midrst_data_out", 32'(bus.data_out), 32'(IDLE_BYTE));
        checkOutput("midrst_grant", 32'(bus.grant), 32'(GRANT_NONE));
        checkOutput("midrst_err", 32'(bus.err_timeout), 32'd0);
        checkOutput("midrst_ready", 32'({bus.s1_ready, bus.s0_ready}), 32'd0);
        @(negedge SYS_CLK);
        RST         = 1'b0;
        ignore_busy = 1'b0;
        rises       = n_req_rise;
        repeat (12) @(negedge SYS_CLK);
        #1;
        checkOutput("midrst_no_rerequest", 32'(n_req_rise - rises), 32'd0);
        checkOutput("midrst_grant_after", 32'(bus.grant), 32'(GRANT_NONE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
